// File: rtl/pixel_coord_scanner_pkg.sv
// Shared types for the pixel coordinate scanner: scanner state encoding and
// the default-width fixed-point coordinate type.
package pixel_coord_scanner_pkg;

  localparam int unsigned COORD_W_DEF = 32;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/credit_counter.sv
// Up/down outstanding-credit counter, saturating at 0 and MAX_CNT, with a
// sticky error flag for returns that arrive when nothing is outstanding.
module credit_counter
  import pixel_coord_scanner_pkg::*;
#(
  parameter int unsigned MAX_CNT = 4,
  parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_err_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Next count and error flag; a same-cycle increment and decrement cancel.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_err_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = '0;
        err_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and error state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/pixel_coord_scanner.sv
// Raster scanner issuing fixed-point pixel coordinates to a downstream ray
// unit, throttled by a credit count of coordinates not yet returned.
module pixel_coord_scanner
  import pixel_coord_scanner_pkg::*;
#(
  parameter int unsigned       H_RES        = 640,
  parameter int unsigned       V_RES        = 480,
  parameter int unsigned       COORD_W      = 32,
  parameter logic [COORD_W-1:0] STEP        = 32'h0020_0000,
  parameter int unsigned       MAX_INFLIGHT = 4
) (
  input  logic                               out_stream_aclk,
  input  logic                               periph_resetn,
  input  logic                               start,
  input  logic                               continuous,
  output logic [COORD_W-1:0]                 coord_x,
  output logic [COORD_W-1:0]                 coord_y,
  output logic                               coord_valid,
  input  logic                               coord_ready,
  output logic                               coord_sof,
  output logic                               coord_eol,
  input  logic                               ret_valid,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               credit_err
);

  localparam int unsigned COL_W = $clog2(H_RES);
  localparam int unsigned ROW_W = $clog2(V_RES);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);

  scan_state_e        state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               frame_done_q, frame_done_d;

  logic               handshake_s;
  logic               start_frame_s;
  logic [CNT_W-1:0]   inflight_s;
  logic               credit_err_s;

  // Valid depends only on registered state, so ret_valid cannot reach it combinationally.
  assign coord_valid   = (state_q == ST_RUN) && (inflight_s < CNT_MAX);
  assign handshake_s   = coord_valid && coord_ready;
  assign start_frame_s = (state_q == ST_IDLE) && start;

  // Next-state, raster counters and coordinate accumulators.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (handshake_s) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            x_d   = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              y_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
              y_d   = y_q + STEP;
            end
          end else begin
            col_d = col_q + COL_W'(1);
            x_d   = x_q + STEP;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (inflight_s == '0) begin
          frame_done_d = 1'b1;
          state_d      = continuous ? ST_RUN : ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
        row_d   = '0;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  // Scanner state registers.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  credit_counter #(
    .MAX_CNT (MAX_INFLIGHT),
    .CNT_W   (CNT_W)
  ) u_credit_counter (
    .clk_i     (out_stream_aclk),
    .rst_ni    (periph_resetn),
    .inc_i     (handshake_s),
    .dec_i     (ret_valid),
    .clr_err_i (start_frame_s),
    .cnt_o     (inflight_s),
    .err_o     (credit_err_s)
  );

  // Markers are gated to RUN so an idle or reset scanner presents all-zero outputs.
  assign coord_sof  = (state_q == ST_RUN) && (col_q == '0) && (row_q == '0);
  assign coord_eol  = (state_q == ST_RUN) && (col_q == COL_LAST);
  assign coord_x    = x_q;
  assign coord_y    = y_q;
  assign inflight   = inflight_s;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign credit_err = credit_err_s;

endmodule
